// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift op encodings, shift-amount width and the
// iterative shifter's state encoding.
package alu_pkg;

  localparam int unsigned SHAMT_W = 5;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shift unit used by iter_shifter.
module shift_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   work,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] s,
  output logic [WIDTH-1:0]   work_next
);

  always_comb begin
    work_next = work;
    case (op)
      SH_SLL:  work_next = work << s;
      SH_SRL:  work_next = work >> s;
      // 2'b10 and 2'b11 both select SRA
      default: work_next = $signed(work) >>> s;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA of B by A[4:0], STEP bits per cycle with single-bit
// steps for the remainder, behind a start/busy/done handshake.
module iter_shifter
  import alu_pkg::*;
#(
  parameter int unsigned STEP  = 1,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [SHAMT_W-1:0] s;
  logic [WIDTH-1:0]   step_out;
  logic               unused_hi;

  assign unused_hi = ^A[WIDTH-1:SHAMT_W];

  // Full STEP while enough amount remains, then single-bit steps
  assign s = (cnt_q >= StepAmt) ? StepAmt : SHAMT_W'(1);

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .work     (work_q),
    .op       (op_q),
    .s        (s),
    .work_next(step_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          work_d  = B;
          cnt_d   = A[SHAMT_W-1:0];
          op_d    = ctrl;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          work_d = step_out;
          cnt_d  = cnt_q - s;
        end else begin
          dout_d  = work_q;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= SH_SLL;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: STEP=1 and STEP=8 instances, table
// vectors, random operations against a one-shot model, and handshake corners.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [2];
  logic [31:0] a     [2];
  logic [31:0] b     [2];
  logic [1:0]  ctrl  [2];
  logic [31:0] dout  [2];
  logic        busy  [2];
  logic        done  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iter_shifter #(.STEP(1), .WIDTH(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .A(a[0]), .B(b[0]), .ctrl(ctrl[0]),
    .dout(dout[0]), .busy(busy[0]), .done(done[0])
  );

  iter_shifter #(.STEP(8), .WIDTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .A(a[1]), .B(b[1]), .ctrl(ctrl[1]),
    .dout(dout[1]), .busy(busy[1]), .done(done[1])
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [31:0] ref_shift(logic [31:0] av, logic [31:0] bv, logic [1:0] cv);
    int n;
    logic signed [31:0] sb;
    n  = int'(av[4:0]);
    sb = bv;
    case (cv)
      2'b00:   return bv << n;
      2'b01:   return bv >> n;
      default: return sb >>> n;
    endcase
  endfunction

  // Edges from the start edge to DONE entry: floor(n/STEP) + n mod STEP + 1
  function automatic int ref_lat(int idx, logic [31:0] av);
    int n;
    int st;
    n  = int'(av[4:0]);
    st = (idx == 0) ? 1 : 8;
    return n / st + n % st + 1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive the request for the next start edge.
  task automatic launch(int idx, logic [31:0] av, logic [31:0] bv, logic [1:0] cv);
    start[idx] = 1'b1;
    a[idx]     = av;
    b[idx]     = bv;
    ctrl[idx]  = cv;
  endtask

  // Waits through one operation already launched. pulse_at >= 0 re-pulses start
  // with a different B during SHIFT. chain drives the next request into the DONE cycle.
  task automatic wait_result(int idx, logic [31:0] exp, int exp_edges, int pulse_at,
                             bit chain, logic [31:0] na, logic [31:0] nb, logic [1:0] nc,
                             string nm);
    int edges;
    int busy_n;
    bit got_done;
    @(posedge clk);
    @(negedge clk);
    start[idx] = 1'b0;
    a[idx]     = $urandom;
    b[idx]     = $urandom;
    ctrl[idx]  = 2'($urandom_range(0, 3));
    edges      = 0;
    busy_n     = busy[idx] ? 1 : 0;
    got_done   = 1'b0;
    while (!got_done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done[idx]) begin
        got_done = 1'b1;
      end else begin
        if (busy[idx]) busy_n++;
        if (edges == pulse_at) begin
          start[idx] = 1'b1;
          b[idx]     = ~exp;
        end else begin
          start[idx] = 1'b0;
        end
      end
    end
    chk({nm, "_done_seen"}, 32'(got_done), 32'd1);
    chk({nm, "_latency"}, 32'(edges), 32'(exp_edges));
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_edges));
    chk({nm, "_busy_in_done"}, 32'(busy[idx]), 32'd0);
    chk({nm, "_dout"}, dout[idx], exp);
    if (chain) begin
      launch(idx, na, nb, nc);
    end else begin
      start[idx] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_single_pulse"}, 32'(done[idx]), 32'd0);
      chk({nm, "_dout_held"}, dout[idx], exp);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, exp2;
    logic [1:0]  rc;

    vecs[0] = '{a: 32'd31,         b: 32'h0000_0001, c: 2'b00, exp: 32'h8000_0000};
    vecs[1] = '{a: 32'd4,          b: 32'h8000_0000, c: 2'b01, exp: 32'h0800_0000};
    vecs[2] = '{a: 32'd4,          b: 32'h8000_0000, c: 2'b11, exp: 32'hF800_0000};
    vecs[3] = '{a: 32'h0000_0020,  b: 32'h1234_5678, c: 2'b10, exp: 32'h1234_5678};
    vecs[4] = '{a: 32'h0000_0021,  b: 32'h1234_5678, c: 2'b00, exp: 32'h2468_ACF0};
    vecs[5] = '{a: 32'd13,         b: 32'h0000_0001, c: 2'b00, exp: 32'h0000_2000};

    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      a[i]     = '0;
      b[i]     = '0;
      ctrl[i]  = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_dout%0d", i), dout[i], 32'h0);
      chk($sformatf("reset_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("reset_done%0d", i), 32'(done[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int idx = 0; idx < 2; idx++) begin
      for (int v = 0; v < 6; v++) begin
        launch(idx, vecs[v].a, vecs[v].b, vecs[v].c);
        wait_result(idx, vecs[v].exp, ref_lat(idx, vecs[v].a), -1, 1'b0, '0, '0, '0,
                    $sformatf("vec%0d_dut%0d", v, idx));
      end
    end

    for (int idx = 0; idx < 2; idx++) begin
      for (int r = 0; r < 40; r++) begin
        ra = $urandom;
        rb = $urandom;
        rc = 2'($urandom_range(0, 3));
        launch(idx, ra, rb, rc);
        wait_result(idx, ref_shift(ra, rb, rc), ref_lat(idx, ra), -1, 1'b0, '0, '0, '0,
                    $sformatf("rand%0d_dut%0d", r, idx));
      end
    end

    // start re-pulsed mid-SHIFT with a different B is ignored
    launch(0, 32'd10, 32'h0000_F0F0, 2'b00);
    wait_result(0, 32'h03C3_C000, 11, 3, 1'b0, '0, '0, '0, "ignore_start");

    // back-to-back: second request held in the DONE cycle
    exp2 = ref_shift(32'd9, 32'h8000_0001, 2'b11);
    launch(1, 32'd13, 32'h0000_0001, 2'b00);
    wait_result(1, 32'h0000_2000, 7, -1, 1'b1, 32'd9, 32'h8000_0001, 2'b11, "b2b_first");
    wait_result(1, exp2, ref_lat(1, 32'd9), -1, 1'b0, '0, '0, '0, "b2b_second");

    // reset in the middle of a 20-bit shift
    launch(0, 32'd20, 32'hABCD_EF01, 2'b00);
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_dout", dout[0], 32'h0);
    chk("midreset_busy", 32'(busy[0]), 32'd0);
    chk("midreset_done", 32'(done[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_no_done", 32'(done[0]), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_no_done", 32'(done[0]), 32'd0);
    end
    launch(0, 32'd20, 32'hABCD_EF01, 2'b01);
    wait_result(0, 32'h0000_0ABC, 21, -1, 1'b0, '0, '0, '0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
